// File: rtl/noc_pkg.sv
// Shared types and width/field helpers for the NoC resource transmitter.
package noc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        CHECK = 2'd2
    } tx_state_e;

    localparam int          CNT_W   = 16;
    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    function automatic int rw_f(input int row_n);
        return $clog2(row_n);
    endfunction

    function automatic int cw_f(input int col_n);
        return $clog2(col_n);
    endfunction

    function automatic int pw_f(input int data_w, input int row_n, input int col_n);
        return data_w + rw_f(row_n) + cw_f(col_n);
    endfunction

    // Packet layout is {row, col, data} with the row in the MSBs.
    localparam int DATA_LSB = 0;

    function automatic int col_lsb(input int data_w);
        return data_w;
    endfunction

    function automatic int row_lsb(input int data_w, input int col_n);
        return data_w + cw_f(col_n);
    endfunction

endpackage

// File: rtl/noc_sync_fifo.sv
// Synchronous first-word-fall-through FIFO holding queued transmit requests.
module noc_sync_fifo #(
    parameter int WIDTH   = 8,
    parameter int DEPTH_W = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int DEPTH = 1 << DEPTH_W;

    logic [WIDTH-1:0]   mem [DEPTH];
    logic [DEPTH_W-1:0] wr_ptr;
    logic [DEPTH_W-1:0] rd_ptr;
    logic [DEPTH_W:0]   count;
    logic               do_push;
    logic               do_pop;

    // A pop frees the slot in the same edge, so a push at full is legal alongside it.
    assign do_pop    = pop_i && !empty_o;
    assign do_push   = push_i && (!full_o || do_pop);
    assign full_o    = (count == (DEPTH_W+1)'(DEPTH));
    assign empty_o   = (count == '0);
    assign rd_data_o = mem[rd_ptr];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= wr_data_i;
    end

endmodule

// File: rtl/noc_rsc_tx.sv
// Core-side transmitter: queues packets for the router local port and resends on overflow.
module noc_rsc_tx
    import noc_pkg::*;
#(
    parameter int   ROW_N        = 3,
    parameter int   COL_M        = 3,
    parameter int   PCKT_DATA_W  = 8,
    parameter int   FIFO_DEPTH_W = 2,
    parameter int   MAX_RETRY    = 3,
    localparam int  RW           = rw_f(ROW_N),
    localparam int  CW           = cw_f(COL_M),
    localparam int  PW           = pw_f(PCKT_DATA_W, ROW_N, COL_M)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic [RW-1:0]          req_row_i,
    input  logic [CW-1:0]          req_col_i,
    input  logic [PCKT_DATA_W-1:0] req_data_i,
    output logic [PW-1:0]          pckt_o,
    output logic                   wren_o,
    input  logic                   full_i,
    input  logic                   ovrflw_i,
    output logic                   drop_o,
    output logic                   err_o,
    output logic [CNT_W-1:0]       sent_cnt_o,
    output logic [CNT_W-1:0]       retry_cnt_o,
    output logic                   busy_o
);

    localparam logic [RW:0]  ROW_LIM   = (RW+1)'(ROW_N);
    localparam logic [CW:0]  COL_LIM   = (CW+1)'(COL_M);
    localparam logic [15:0]  RETRY_LIM = 16'(MAX_RETRY);
    localparam int           ROW_LSB   = row_lsb(PCKT_DATA_W, COL_M);
    localparam int           COL_LSB   = col_lsb(PCKT_DATA_W);

    tx_state_e       state_q, state_d;
    logic [PW-1:0]   pckt_in;
    logic [PW-1:0]   fifo_head;
    logic            fifo_full, fifo_empty;
    logic            accept, dest_ok, push;
    logic            load_c, pop_c, sent_c, retry_c, drop_c;
    logic [15:0]     retry_q;

    assign accept      = req_valid_i && req_ready_o;
    assign dest_ok     = ({1'b0, req_row_i} < ROW_LIM) && ({1'b0, req_col_i} < COL_LIM);
    assign push        = accept && dest_ok;
    assign req_ready_o = !fifo_full;
    assign busy_o      = !fifo_empty || (state_q != IDLE);

    always_comb begin
        pckt_in                             = '0;
        pckt_in[ROW_LSB +: RW]              = req_row_i;
        pckt_in[COL_LSB +: CW]              = req_col_i;
        pckt_in[DATA_LSB +: PCKT_DATA_W]    = req_data_i;
    end

    noc_sync_fifo #(
        .WIDTH   (PW),
        .DEPTH_W (FIFO_DEPTH_W)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .push_i    (push),
        .wr_data_i (pckt_in),
        .pop_i     (pop_c),
        .rd_data_o (fifo_head),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!fifo_empty && !full_i) state_d = SEND;
            SEND:    state_d = CHECK;
            CHECK:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The head stays queued across resends; it only leaves on delivery or drop.
    always_comb begin
        wren_o  = 1'b0;
        load_c  = 1'b0;
        pop_c   = 1'b0;
        sent_c  = 1'b0;
        retry_c = 1'b0;
        drop_c  = 1'b0;
        case (state_q)
            IDLE:  load_c = !fifo_empty && !full_i;
            SEND:  wren_o = 1'b1;
            CHECK: begin
                if (!ovrflw_i) begin
                    pop_c  = 1'b1;
                    sent_c = 1'b1;
                end else if (retry_q != RETRY_LIM) begin
                    retry_c = 1'b1;
                end else begin
                    pop_c  = 1'b1;
                    drop_c = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pckt_o      <= '0;
            drop_o      <= 1'b0;
            err_o       <= 1'b0;
            sent_cnt_o  <= '0;
            retry_cnt_o <= '0;
            retry_q     <= '0;
        end else begin
            if (load_c) pckt_o <= fifo_head;
            drop_o <= drop_c;
            err_o  <= accept && !dest_ok;
            if (sent_c && (sent_cnt_o != CNT_MAX))   sent_cnt_o  <= sent_cnt_o + 1'b1;
            if (retry_c && (retry_cnt_o != CNT_MAX)) retry_cnt_o <= retry_cnt_o + 1'b1;
            if (retry_c)    retry_q <= retry_q + 1'b1;
            else if (pop_c) retry_q <= '0;
        end
    end

endmodule

// File: tb/tb_noc_rsc_tx.sv
// Directed bench for noc_rsc_tx: send, backpressure, retry, drop, bad destination, full queue, reset.
module tb_noc_rsc_tx;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [1:0]  req_row_i;
    logic [1:0]  req_col_i;
    logic [7:0]  req_data_i;
    logic [11:0] pckt_o;
    logic        wren_o;
    logic        full_i;
    logic        ovrflw_i;
    logic        drop_o;
    logic        err_o;
    logic [15:0] sent_cnt_o;
    logic [15:0] retry_cnt_o;
    logic        busy_o;

    int          check_cnt = 0;
    int          pass_cnt  = 0;
    int          cyc       = 0;
    int          drop_n    = 0;
    logic [11:0] wr_pk[$];
    int          wr_cyc[$];

    noc_rsc_tx #(
        .ROW_N        (3),
        .COL_M        (3),
        .PCKT_DATA_W  (8),
        .FIFO_DEPTH_W (2),
        .MAX_RETRY    (3)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_row_i   (req_row_i),
        .req_col_i   (req_col_i),
        .req_data_i  (req_data_i),
        .pckt_o      (pckt_o),
        .wren_o      (wren_o),
        .full_i      (full_i),
        .ovrflw_i    (ovrflw_i),
        .drop_o      (drop_o),
        .err_o       (err_o),
        .sent_cnt_o  (sent_cnt_o),
        .retry_cnt_o (retry_cnt_o),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    // Record every strobe with its cycle so ordering and spacing can be checked afterwards.
    always @(negedge clk_i) begin
        if (wren_o === 1'b1) begin
            wr_pk.push_back(pckt_o);
            wr_cyc.push_back(cyc);
        end
        if (drop_o === 1'b1) drop_n++;
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic apply_reset();
        @(negedge clk_i);
        rst_i       = 1'b1;
        req_valid_i = 1'b0;
        req_row_i   = '0;
        req_col_i   = '0;
        req_data_i  = '0;
        full_i      = 1'b0;
        ovrflw_i    = 1'b0;
        step(2);
        rst_i = 1'b0;
        wr_pk.delete();
        wr_cyc.delete();
        drop_n = 0;
    endtask

    task automatic push_pkt(input logic [1:0] r, input logic [1:0] c, input logic [7:0] d);
        @(negedge clk_i);
        req_valid_i = 1'b1;
        req_row_i   = r;
        req_col_i   = c;
        req_data_i  = d;
        @(negedge clk_i);
        req_valid_i = 1'b0;
    endtask

    task automatic wait_wren(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk_i);
            if (wren_o === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_i);
            if (busy_o === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1; req_valid_i = 1'b0; req_row_i = '0; req_col_i = '0; req_data_i = '0;
        full_i = 1'b0; ovrflw_i = 1'b0;
        step(3);
        check_cnt++; if (wren_o !== 1'b0) $display("[TB] FAIL reset_wren: got %b want 0", wren_o); else pass_cnt++;
        check_cnt++; if (pckt_o !== 12'h000) $display("[TB] FAIL reset_pckt: got %h want 000", pckt_o); else pass_cnt++;
        check_cnt++; if (drop_o !== 1'b0) $display("[TB] FAIL reset_drop: got %b want 0", drop_o); else pass_cnt++;
        check_cnt++; if (err_o !== 1'b0) $display("[TB] FAIL reset_err: got %b want 0", err_o); else pass_cnt++;
        check_cnt++; if (sent_cnt_o !== 16'd0) $display("[TB] FAIL reset_sent: got %0d want 0", sent_cnt_o); else pass_cnt++;
        check_cnt++; if (retry_cnt_o !== 16'd0) $display("[TB] FAIL reset_retry: got %0d want 0", retry_cnt_o); else pass_cnt++;
        check_cnt++; if (busy_o !== 1'b0) $display("[TB] FAIL reset_busy: got %b want 0", busy_o); else pass_cnt++;
        rst_i = 1'b0;
        step(1);
        check_cnt++; if (req_ready_o !== 1'b1) $display("[TB] FAIL reset_ready: got %b want 1", req_ready_o); else pass_cnt++;
    endtask

    task automatic test_single_send();
        apply_reset();
        push_pkt(2'd1, 2'd2, 8'hA5);
        check_cnt++; if (wren_o !== 1'b0) $display("[TB] FAIL single_wren_n1: got %b want 0", wren_o); else pass_cnt++;
        check_cnt++; if (busy_o !== 1'b1) $display("[TB] FAIL single_busy: got %b want 1", busy_o); else pass_cnt++;
        step(1);
        check_cnt++; if (wren_o !== 1'b1) $display("[TB] FAIL single_wren_n2: got %b want 1", wren_o); else pass_cnt++;
        check_cnt++; if (pckt_o !== 12'h6A5) $display("[TB] FAIL single_pckt: got %h want 6a5", pckt_o); else pass_cnt++;
        step(1);
        check_cnt++; if (wren_o !== 1'b0) $display("[TB] FAIL single_wren_check: got %b want 0", wren_o); else pass_cnt++;
        step(1);
        check_cnt++; if (sent_cnt_o !== 16'd1) $display("[TB] FAIL single_sent: got %0d want 1", sent_cnt_o); else pass_cnt++;
        check_cnt++; if (busy_o !== 1'b0) $display("[TB] FAIL single_idle: got %b want 0", busy_o); else pass_cnt++;
        check_cnt++; if (pckt_o !== 12'h6A5) $display("[TB] FAIL single_hold: got %h want 6a5", pckt_o); else pass_cnt++;
    endtask

    task automatic test_backpressure();
        logic [11:0] exp_pk [3];
        bit ok;
        exp_pk[0] = 12'h011; exp_pk[1] = 12'h522; exp_pk[2] = 12'hA33;
        apply_reset();
        full_i = 1'b1;
        push_pkt(2'd0, 2'd0, 8'h11);
        push_pkt(2'd1, 2'd1, 8'h22);
        push_pkt(2'd2, 2'd2, 8'h33);
        step(6);
        check_cnt++; if (wr_pk.size() != 0) $display("[TB] FAIL bp_blocked: got %0d strobes want 0", wr_pk.size()); else pass_cnt++;
        check_cnt++; if (busy_o !== 1'b1) $display("[TB] FAIL bp_busy: got %b want 1", busy_o); else pass_cnt++;
        full_i = 1'b0;
        wait_idle(ok);
        check_cnt++; if (!ok) $display("[TB] FAIL bp_timeout: got busy want idle"); else pass_cnt++;
        check_cnt++; if (wr_pk.size() != 3) $display("[TB] FAIL bp_count: got %0d strobes want 3", wr_pk.size()); else pass_cnt++;
        if (wr_pk.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                check_cnt++; if (wr_pk[i] !== exp_pk[i]) $display("[TB] FAIL bp_pckt%0d: got %h want %h", i, wr_pk[i], exp_pk[i]); else pass_cnt++;
            end
            for (int i = 1; i < 3; i++) begin
                check_cnt++; if (wr_cyc[i] - wr_cyc[i-1] != 3) $display("[TB] FAIL bp_gap%0d: got %0d want 3", i, wr_cyc[i] - wr_cyc[i-1]); else pass_cnt++;
            end
        end
        check_cnt++; if (sent_cnt_o !== 16'd3) $display("[TB] FAIL bp_sent: got %0d want 3", sent_cnt_o); else pass_cnt++;
    endtask

    task automatic test_retry();
        bit ok;
        apply_reset();
        push_pkt(2'd2, 2'd1, 8'h5A);
        wait_wren(ok);
        check_cnt++; if (!ok) $display("[TB] FAIL retry_timeout: got no strobe want strobe"); else pass_cnt++;
        step(1);
        ovrflw_i = 1'b1;
        step(1);
        ovrflw_i = 1'b0;
        wait_idle(ok);
        check_cnt++; if (wr_pk.size() != 2) $display("[TB] FAIL retry_count: got %0d strobes want 2", wr_pk.size()); else pass_cnt++;
        if (wr_pk.size() == 2) begin
            check_cnt++; if (wr_pk[0] !== 12'h95A) $display("[TB] FAIL retry_first: got %h want 95a", wr_pk[0]); else pass_cnt++;
            check_cnt++; if (wr_pk[1] !== 12'h95A) $display("[TB] FAIL retry_resend: got %h want 95a", wr_pk[1]); else pass_cnt++;
            check_cnt++; if (wr_cyc[1] - wr_cyc[0] != 3) $display("[TB] FAIL retry_gap: got %0d want 3", wr_cyc[1] - wr_cyc[0]); else pass_cnt++;
        end
        check_cnt++; if (retry_cnt_o !== 16'd1) $display("[TB] FAIL retry_cnt: got %0d want 1", retry_cnt_o); else pass_cnt++;
        check_cnt++; if (sent_cnt_o !== 16'd1) $display("[TB] FAIL retry_sent: got %0d want 1", sent_cnt_o); else pass_cnt++;
        check_cnt++; if (drop_n != 0) $display("[TB] FAIL retry_nodrop: got %0d drops want 0", drop_n); else pass_cnt++;
    endtask

    task automatic test_drop();
        bit ok;
        apply_reset();
        ovrflw_i = 1'b1;
        push_pkt(2'd0, 2'd2, 8'hC3);
        push_pkt(2'd1, 2'd0, 8'h3C);
        ok = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk_i);
            if (drop_o === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        check_cnt++; if (!ok) $display("[TB] FAIL drop_timeout: got no drop want drop"); else pass_cnt++;
        check_cnt++; if (sent_cnt_o !== 16'd0) $display("[TB] FAIL drop_sent0: got %0d want 0", sent_cnt_o); else pass_cnt++;
        check_cnt++; if (wr_pk.size() != 4) $display("[TB] FAIL drop_strobes: got %0d want 4", wr_pk.size()); else pass_cnt++;
        ovrflw_i = 1'b0;
        step(1);
        check_cnt++; if (drop_o !== 1'b0) $display("[TB] FAIL drop_pulse: got %b want 0", drop_o); else pass_cnt++;
        wait_idle(ok);
        check_cnt++; if (wr_pk.size() != 5) $display("[TB] FAIL drop_total: got %0d want 5", wr_pk.size()); else pass_cnt++;
        if (wr_pk.size() == 5) begin
            for (int i = 0; i < 4; i++) begin
                check_cnt++; if (wr_pk[i] !== 12'h2C3) $display("[TB] FAIL drop_pckt%0d: got %h want 2c3", i, wr_pk[i]); else pass_cnt++;
            end
            check_cnt++; if (wr_pk[4] !== 12'h43C) $display("[TB] FAIL drop_next: got %h want 43c", wr_pk[4]); else pass_cnt++;
        end
        check_cnt++; if (drop_n != 1) $display("[TB] FAIL drop_n: got %0d want 1", drop_n); else pass_cnt++;
        check_cnt++; if (retry_cnt_o !== 16'd3) $display("[TB] FAIL drop_retry: got %0d want 3", retry_cnt_o); else pass_cnt++;
        check_cnt++; if (sent_cnt_o !== 16'd1) $display("[TB] FAIL drop_sent1: got %0d want 1", sent_cnt_o); else pass_cnt++;
    endtask

    task automatic test_bad_dest();
        apply_reset();
        push_pkt(2'd3, 2'd0, 8'hEE);
        check_cnt++; if (err_o !== 1'b1) $display("[TB] FAIL bad_row_err: got %b want 1", err_o); else pass_cnt++;
        check_cnt++; if (busy_o !== 1'b0) $display("[TB] FAIL bad_row_busy: got %b want 0", busy_o); else pass_cnt++;
        step(1);
        check_cnt++; if (err_o !== 1'b0) $display("[TB] FAIL bad_row_pulse: got %b want 0", err_o); else pass_cnt++;
        push_pkt(2'd0, 2'd3, 8'h77);
        check_cnt++; if (err_o !== 1'b1) $display("[TB] FAIL bad_col_err: got %b want 1", err_o); else pass_cnt++;
        step(5);
        check_cnt++; if (wr_pk.size() != 0) $display("[TB] FAIL bad_nostrobe: got %0d want 0", wr_pk.size()); else pass_cnt++;
    endtask

    task automatic test_full_queue();
        bit ok;
        logic [11:0] exp;
        apply_reset();
        full_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            req_valid_i = 1'b1;
            req_row_i   = 2'(i % 3);
            req_col_i   = 2'((i + 1) % 3);
            req_data_i  = 8'h10 + 8'(i);
            check_cnt++; if (req_ready_o !== (i < 4)) $display("[TB] FAIL full_ready%0d: got %b want %b", i, req_ready_o, (i < 4)); else pass_cnt++;
        end
        @(negedge clk_i);
        req_valid_i = 1'b0;
        full_i = 1'b0;
        wait_idle(ok);
        check_cnt++; if (wr_pk.size() != 4) $display("[TB] FAIL full_count: got %0d want 4", wr_pk.size()); else pass_cnt++;
        if (wr_pk.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                exp = {2'(i % 3), 2'((i + 1) % 3), 8'h10 + 8'(i)};
                check_cnt++; if (wr_pk[i] !== exp) $display("[TB] FAIL full_pckt%0d: got %h want %h", i, wr_pk[i], exp); else pass_cnt++;
            end
        end
        check_cnt++; if (sent_cnt_o !== 16'd4) $display("[TB] FAIL full_sent: got %0d want 4", sent_cnt_o); else pass_cnt++;
    endtask

    task automatic test_reset_mid_send();
        bit ok;
        apply_reset();
        push_pkt(2'd2, 2'd2, 8'hFF);
        wait_wren(ok);
        check_cnt++; if (!ok) $display("[TB] FAIL midrst_timeout: got no strobe want strobe"); else pass_cnt++;
        rst_i = 1'b1;
        step(1);
        check_cnt++; if (wren_o !== 1'b0) $display("[TB] FAIL midrst_wren: got %b want 0", wren_o); else pass_cnt++;
        check_cnt++; if (pckt_o !== 12'h000) $display("[TB] FAIL midrst_pckt: got %h want 000", pckt_o); else pass_cnt++;
        check_cnt++; if (busy_o !== 1'b0) $display("[TB] FAIL midrst_busy: got %b want 0", busy_o); else pass_cnt++;
        check_cnt++; if (drop_o !== 1'b0) $display("[TB] FAIL midrst_drop: got %b want 0", drop_o); else pass_cnt++;
        check_cnt++; if (sent_cnt_o !== 16'd0) $display("[TB] FAIL midrst_sent: got %0d want 0", sent_cnt_o); else pass_cnt++;
        rst_i = 1'b0;
        step(4);
        check_cnt++; if (drop_n != 0) $display("[TB] FAIL midrst_nodrop: got %0d want 0", drop_n); else pass_cnt++;
        check_cnt++; if (wr_pk.size() != 1) $display("[TB] FAIL midrst_discard: got %0d strobes want 1", wr_pk.size()); else pass_cnt++;
        check_cnt++; if (req_ready_o !== 1'b1) $display("[TB] FAIL midrst_ready: got %b want 1", req_ready_o); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single_send();
        test_backpressure();
        test_retry();
        test_drop();
        test_bad_dest();
        test_full_queue();
        test_reset_mid_send();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no completion want completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
